vram_arbiter: RTL and testbench

Shares the single-port, synchronous-read VRAM between the VGA scan-out reader and the CPU bus port (the VRAM window at 0x000c0000 decoded by the bus). VGA always wins the port. CPU writes are posted into a small FIFO and retired in free cycles. CPU reads stall the CPU until the FIFO has drained and a free slot has returned data.

---
 rtl/vram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port, synchronous-read VRAM between the VGA scan-out reader and the CPU bus.
// Latency: a VGA read returns data 1 cycle after vga_req_i. A CPU read returns data no earlier than 2 cycles after the request.
//          Posted CPU writes retire in the first non-VGA cycle after they reach the head of the FIFO.
// Backpressure: VGA is never stalled. cpu_stall_o is combinational and rises for a write only while the FIFO is full and no pop is possible.
//               For a read, cpu_stall_o stays high until the read data is ready.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   vga_req_i/vga_addr_i         VGA read request and address
//   vga_data_o/vga_valid_o       VGA read data (straight from VRAM) and its valid flag, 1 cycle later
//   cpu_sel_i/cpu_we_i           CPU VRAM access strobe and direction (1 = write)
//   cpu_addr_i/cpu_wdata_i       CPU address and write data
//   cpu_rdata_o                  registered CPU read data
//   cpu_stall_o                  CPU must hold its request while this is high
//   vram_addr_o/din_o/we_o       VRAM port, owned by one requester per cycle
//   vram_dout_i                  VRAM read data, valid one cycle after the address
//   fifo_count_o                 number of posted writes still pending
module vram_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          vga_req_i,
    input  logic [AW-1:0]                 vga_addr_i,
    output logic [DW-1:0]                 vga_data_o,
    output logic                          vga_valid_o,
    input  logic                          cpu_sel_i,
    input  logic                          cpu_we_i,
    input  logic [AW-1:0]                 cpu_addr_i,
    input  logic [DW-1:0]                 cpu_wdata_i,
    output logic [DW-1:0]                 cpu_rdata_o,
    output logic                          cpu_stall_o,
    output logic [AW-1:0]                 vram_addr_o,
    output logic [DW-1:0]                 vram_din_o,
    output logic                          vram_we_o,
    input  logic [DW-1:0]                 vram_dout_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA,
        R_DONE
    } rd_state_e;

    // Posted-write FIFO storage and pointers
    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    rd_state_e     state_q, state_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          vga_valid_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic rd_req;
    logic rd_issue;
    logic wr_stall;
    logic rd_stall;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    // VGA owns the slot outright, so the FIFO only drains in cycles without a VGA read.
    assign pop    = ~vga_req_i & ~fifo_empty;
    // A full FIFO still accepts a write in a cycle where the head is leaving.
    assign push   = cpu_sel_i & cpu_we_i & (~fifo_full | pop);
    assign rd_req = cpu_sel_i & ~cpu_we_i;

    assign wr_stall    = cpu_sel_i & cpu_we_i & fifo_full & ~pop;
    assign rd_stall    = rd_req & (state_q != R_DONE);
    assign cpu_stall_o = wr_stall | rd_stall;

    // Read FSM. A read waits until the FIFO is empty, so it always sees earlier posted writes
    // without any address comparison.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (rd_req) begin
                    if (fifo_empty && !vga_req_i) begin
                        rd_issue = 1'b1;
                        state_d  = R_DATA;
                    end else begin
                        state_d  = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (fifo_empty && !vga_req_i) begin
                    rd_issue = 1'b1;
                    state_d  = R_DATA;
                end
            end
            R_DATA:  state_d = R_DONE;
            R_DONE:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // VRAM slot mux, in priority order: VGA, FIFO head, CPU read, idle.
    always_comb begin
        vram_addr_o = '0;
        vram_din_o  = '0;
        vram_we_o   = 1'b0;
        if (vga_req_i) begin
            vram_addr_o = vga_addr_i;
        end else if (pop) begin
            vram_addr_o = fifo_addr_q[rd_ptr_q];
            vram_din_o  = fifo_data_q[rd_ptr_q];
            vram_we_o   = 1'b1;
        end else if (rd_issue) begin
            vram_addr_o = cpu_addr_i;
        end
    end

    // Next-state values for the FIFO bookkeeping and read data.
    // The pointers wrap on their own because the depth is a power of two.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        cpu_rdata_d = cpu_rdata_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The VRAM returns the data for the address issued last cycle.
        if (state_q == R_DATA) begin
            cpu_rdata_d = vram_dout_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= R_IDLE;
            cpu_rdata_q <= '0;
            vga_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_valid_q <= vga_req_i;
        end
    end

    // The FIFO storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr_i;
            fifo_data_q[wr_ptr_q] <= cpu_wdata_i;
        end
    end

    assign vga_data_o   = vram_dout_i;
    assign vga_valid_o  = vga_valid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 12;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            vga_req;
    logic [AW-1:0]   vga_addr;
    logic [DW-1:0]   vga_data;
    logic            vga_valid;
    logic            cpu_sel;
    logic            cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_stall;
    logic [AW-1:0]   vram_addr;
    logic [DW-1:0]   vram_din;
    logic            vram_we;
    logic [DW-1:0]   vram_dout;
    logic [2:0]      fifo_count;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .vga_req_i    (vga_req),
        .vga_addr_i   (vga_addr),
        .vga_data_o   (vga_data),
        .vga_valid_o  (vga_valid),
        .cpu_sel_i    (cpu_sel),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_stall_o  (cpu_stall),
        .vram_addr_o  (vram_addr),
        .vram_din_o   (vram_din),
        .vram_we_o    (vram_we),
        .vram_dout_i  (vram_dout),
        .fifo_count_o (fifo_count)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(32'(a) * 37 + 5);
    endfunction

    // Behavioural synchronous-read VRAM; unwritten locations read back a fixed pattern
    logic [DW-1:0] vram [2**AW];
    bit            vram_seen [2**AW];
    always @(posedge clk) begin
        if (vram_we === 1'b1) begin
            vram[vram_addr]      <= vram_din;
            vram_seen[vram_addr] <= 1'b1;
        end
        vram_dout <= vram_seen[vram_addr] ? vram[vram_addr] : pat(vram_addr);
    end

    // Reference memory, updated only with expected write data
    logic [DW-1:0] ref_mem [2**AW];
    bit            ref_seen [2**AW];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    typedef struct {
        logic [AW-1:0] a;
        int            c;
    } vg_t;
    wr_t wr_q[$];
    vg_t vga_q[$];

    typedef struct {
        int vga, sel, we, nw, a, d, es, ew, ec;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; expectations are queued as stimulus goes out
    task automatic set_in(input int vga, input int sel, input int we, input int nw,
                          input int a, input int d);
        vg_t v;
        vga_req   = vga[0];
        vga_addr  = AW'(cyc * 5 + 3);
        cpu_sel   = sel[0];
        cpu_we    = we[0];
        cpu_addr  = AW'(a);
        cpu_wdata = DW'(d);
        if (vga != 0) begin
            v.a = vga_addr;
            v.c = cyc;
            vga_q.push_back(v);
        end
        if (sel != 0 && we != 0 && nw != 0) wr_q.push_back({AW'(a), DW'(d)});
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin : mon
        wr_t we_e;
        vg_t vg_e;
        if (mon_en) begin
            if (vram_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_vram_write", 32'(vram_addr), 32'hFFFF_FFFF);
                end else begin
                    we_e = wr_q.pop_front();
                    check("wr_addr", 32'(vram_addr), 32'(we_e.a));
                    check("wr_data", 32'(vram_din), 32'(we_e.d));
                    ref_mem[we_e.a]  = we_e.d;
                    ref_seen[we_e.a] = 1'b1;
                end
            end
            if (vga_valid === 1'b1) begin
                if (vga_q.size() == 0) begin
                    check("unexpected_vga_valid", 32'(vga_valid), 32'h0);
                end else begin
                    vg_e = vga_q.pop_front();
                    check("vga_latency", 32'(cyc), 32'(vg_e.c + 1));
                    check("vga_data", 32'(vga_data),
                          32'(ref_seen[vg_e.a] ? ref_mem[vg_e.a] : pat(vg_e.a)));
                end
            end
        end
    end

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_count == 0) break;
            @(posedge clk);
            #1;
        end
        check(nm, 32'(fifo_count), 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Issue a read and hold it until the stall drops; the VGA is busy for the first nvga cycles
    task automatic do_read(input string nm, input int a, input int nvga, input int exp_stall,
                           input int exp_data, input bit no_we);
        int n       = 0;
        bit done    = 1'b0;
        bit we_seen = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            set_in((k < nvga) ? 1 : 0, 1, 0, 0, a, 0);
            @(negedge clk);
            if (vram_we === 1'b1) we_seen = 1'b1;
            if (cpu_stall !== 1'b0) begin
                n++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        check({nm, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check({nm, "_rdata"}, 32'(cpu_rdata), 32'(exp_data));
        if (no_we) check({nm, "_no_vram_we"}, 32'(we_seen), 32'h0);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: {vga, sel, we, new_write, addr, wdata, exp_stall, exp_vram_we, exp_count}
        // VGA priority: three writes posted under a 5-cycle VGA burst, retired in cycles 5..7
        vq.push_back('{1, 1, 1, 1, 'h100, 'h1A1, 0, 0, 0});
        vq.push_back('{1, 1, 1, 1, 'h101, 'h1A2, 0, 0, 1});
        vq.push_back('{1, 1, 1, 1, 'h102, 'h1A3, 0, 0, 2});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 3});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 3});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 3});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 2});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        // FIFO full: the 5th write stalls, then is accepted alongside the first pop
        vq.push_back('{1, 1, 1, 1, 'h200, 'h2B0, 0, 0, 0});
        vq.push_back('{1, 1, 1, 1, 'h201, 'h2B1, 0, 0, 1});
        vq.push_back('{1, 1, 1, 1, 'h202, 'h2B2, 0, 0, 2});
        vq.push_back('{1, 1, 1, 1, 'h203, 'h2B3, 0, 0, 3});
        vq.push_back('{1, 1, 1, 1, 'h204, 'h2B4, 1, 0, 4});
        vq.push_back('{0, 1, 1, 0, 'h204, 'h2B4, 0, 1, 4});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 4});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 3});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 2});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        next_cyc();
        next_cyc();
        @(negedge clk);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_vga_valid", 32'(vga_valid), 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        check("rst_vram_we", 32'(vram_we), 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle read after a retired write
        set_in(0, 1, 1, 1, 'h10, 'hABC);
        next_cyc();
        set_in(0, 0, 0, 0, 0, 0);
        wait_drain("idle_drain");
        do_read("idle_read", 'h10, 0, 2, 'hABC, 1'b1);

        // VGA priority and FIFO-full vectors
        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].vga, vq[i].sel, vq[i].we, vq[i].nw, vq[i].a, vq[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vq[i].es));
            check($sformatf("vec%0d_vram_we", i), 32'(vram_we), 32'(vq[i].ew));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vq[i].ec));
            @(posedge clk);
            #1;
        end
        set_in(0, 0, 0, 0, 0, 0);
        wait_drain("vec_drain");

        // Read-after-write: two writes held pending by VGA, then a read of the same address
        set_in(1, 1, 1, 1, 'h20, 'h111);
        next_cyc();
        set_in(1, 1, 1, 1, 'h20, 'h222);
        next_cyc();
        do_read("raw", 'h20, 0, 4, 'h222, 1'b0);

        // Read blocked by VGA for cycles 0..3
        do_read("vga_block", 'h10, 4, 6, 'hABC, 1'b1);

        // Reset mid-operation: 3 pending writes and a read waiting
        set_in(1, 1, 1, 1, 'h30, 'h301);
        next_cyc();
        set_in(1, 1, 1, 1, 'h31, 'h302);
        next_cyc();
        set_in(1, 1, 1, 1, 'h32, 'h303);
        next_cyc();
        set_in(1, 1, 0, 0, 'h40, 0);
        @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 32'h3);
        check("pre_rst_read_stall", 32'(cpu_stall), 32'h1);
        @(posedge clk);
        #1;
        set_in(1, 1, 0, 0, 'h40, 0);
        @(negedge clk);
        check("wait_read_stall", 32'(cpu_stall), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0);
        next_cyc();
        rst = 1'b0;
        wr_q.delete();
        vga_q.delete();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        check("mid_rst_rdata", 32'(cpu_rdata), 32'h0);
        check("mid_rst_stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1;
        repeat (6) next_cyc();
        do_read("post_rst_read", 'h20, 0, 2, 'h222, 1'b1);

        repeat (3) next_cyc();
        check("wr_queue_empty", 32'(wr_q.size()), 32'h0);
        check("vga_queue_empty", 32'(vga_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
